// File: rtl/waterfall_pkg.sv
// Shared framebuffer geometry and writer state encoding for the waterfall display path
// (writer, framebuffer and display reader).
package waterfall_pkg;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;
  localparam int FB_FRAME  = 76800;
  localparam int FB_ADDR_W = 17;
  localparam int FB_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAD   = 2'd2,
    ST_DRAIN = 2'd3
  } wf_state_e;

endpackage

// File: rtl/waterfall_writer.sv
// Streams spectrum lines into a circular framebuffer, padding short lines and dropping
// overlong ones, with a zero-fill clear pass after reset or on request.
module waterfall_writer
  import waterfall_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              mem_ready,
  input  logic              clear_req,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              w_enable,
  output logic [7:0]        head_row,
  output logic              line_done,
  output logic              clearing,
  output logic              err_overrun
);

  localparam int FRAME = WIDTH * HEIGHT;
  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(FRAME - 1);

  wf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              err_q, err_d;

  logic col_last;
  logic line_write;

  assign col_last = (col_q == COL_LAST);

  // Handshake and write strobe are combinational so an accepted beat is written the same cycle.
  always_comb begin
    s_ready  = 1'b0;
    w_enable = 1'b0;
    wdata    = '0;
    case (state_q)
      ST_RUN: begin
        s_ready  = mem_ready;
        w_enable = s_valid && mem_ready;
        wdata    = s_data;
      end
      ST_PAD:   w_enable = mem_ready;
      ST_DRAIN: s_ready  = 1'b1;
      ST_CLEAR: w_enable = mem_ready;
      default: ;
    endcase
    if (reset) begin
      w_enable = 1'b0;
    end
  end

  assign line_write  = w_enable && (state_q == ST_RUN || state_q == ST_PAD);
  assign line_done   = line_write && col_last;
  assign addr        = ptr_q;
  assign head_row    = 8'(row_q);
  assign clearing    = (state_q == ST_CLEAR);
  assign err_overrun = err_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    col_d   = col_q;
    row_d   = row_q;
    err_d   = err_q;

    // Position bookkeeping for line writes; row wrap also wraps the pointer so no multiply is needed.
    if (line_write) begin
      if (col_last) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d = '0;
          ptr_d = '0;
        end else begin
          row_d = row_q + ROW_W'(1);
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
        ptr_d = ptr_q + ADDR_W'(1);
      end
    end

    case (state_q)
      ST_RUN: begin
        if (s_valid && mem_ready) begin
          if (col_last && !s_last) begin
            state_d = ST_DRAIN;
            err_d   = 1'b1;
          end else if (!col_last && s_last) begin
            state_d = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        if (mem_ready && col_last) begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (s_valid && s_last) begin
          state_d = ST_RUN;
        end
      end
      ST_CLEAR: begin
        if (mem_ready) begin
          if (ptr_q == PTR_LAST) begin
            ptr_d   = '0;
            col_d   = '0;
            row_d   = '0;
            state_d = ST_RUN;
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    // A clear request abandons whatever line is in progress and restarts the fill from zero.
    if (clear_req) begin
      state_d = ST_CLEAR;
      ptr_d   = '0;
      col_d   = '0;
      row_d   = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      err_q   <= err_d;
    end
  end

endmodule
